// File: rtl/fpu_mult_seq.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU: one multiplier bit per
// cycle, then a sign-fix cycle, then a one-cycle done pulse with the 2*WIDTH product.
module fpu_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             FPUctrl,
  input  logic [WIDTH-1:0] fbusA,
  input  logic [WIDTH-1:0] fbusB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] FPUout,
  output logic [WIDTH-1:0] FPUoutHi,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic                 sign_q, sign_d;
  logic                 mode_q, mode_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     outHi_q, outHi_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH-1:0]     absA, absB;
  logic [WIDTH:0]       upperSum;
  logic [2*WIDTH-1:0]   product;

  // Signed mode works on magnitudes; the most negative value maps onto itself as unsigned.
  assign absA = (!FPUctrl && fbusA[WIDTH-1]) ? (~fbusA + 1'b1) : fbusA;
  assign absB = (!FPUctrl && fbusB[WIDTH-1]) ? (~fbusB + 1'b1) : fbusB;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      outHi_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      outHi_q <= outHi_d;
      ovf_q   <= ovf_d;
    end
  end

  // The multiplier sits in the low half of the accumulator and is consumed as the product shifts in.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    mode_d   = mode_q;
    out_d    = out_q;
    outHi_d  = outHi_q;
    ovf_d    = ovf_q;
    upperSum = '0;
    product  = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          mcand_d = absA;
          acc_d   = {{(WIDTH+1){1'b0}}, absB};
          count_d = '0;
          sign_d  = !FPUctrl && (fbusA[WIDTH-1] ^ fbusB[WIDTH-1]);
          mode_d  = FPUctrl;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        upperSum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_d    = {1'b0, upperSum, acc_q[WIDTH-1:1]};
        if (count_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      FIX: begin
        product = sign_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
        out_d   = product[WIDTH-1:0];
        outHi_d = product[2*WIDTH-1:WIDTH];
        ovf_d   = mode_q ? (product[2*WIDTH-1:WIDTH] != '0)
                         : (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign FPUout   = out_q;
  assign FPUoutHi = outHi_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fpu_mult_seq.sv
// Self-checking bench for fpu_mult_seq: directed cases, back-to-back issue,
// ignored start, reset abort, and random operands against a 64-bit arithmetic model.
module tb_fpu_mult_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        FPUctrl = 1'b0;
  logic [31:0] fbusA = '0;
  logic [31:0] fbusB = '0;
  logic        busy, done, ovf;
  logic [31:0] FPUout, FPUoutHi;

  int tests = 0;
  int fails = 0;

  // Edges from the start-sampling edge to the first edge where done is seen (34 cycles incl. start cycle).
  localparam int LAT = 33;

  fpu_mult_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .FPUctrl(FPUctrl),
    .fbusA(fbusA), .fbusB(fbusB), .busy(busy), .done(done),
    .FPUout(FPUout), .FPUoutHi(FPUoutHi), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b, input logic unsMode);
    longint sa, sb;
    if (unsMode) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic refOvf(input logic [63:0] p, input logic unsMode);
    if (unsMode) return p[63:32] != 32'h0;
    return p[63:32] != {32{p[31]}};
  endfunction

  // Called #1 after an edge; leaves the bench #1 after the edge that sampled start.
  task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic m);
    fbusA = a; fbusB = b; FPUctrl = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fbusA = $urandom; fbusB = $urandom; FPUctrl = 1'($urandom);
  endtask

  task automatic waitDone(output int lat, output logic [31:0] lo, output logic [31:0] hi, output logic o);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    lo = FPUout; hi = FPUoutHi; o = ovf;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", done); end
    tests++; if (FPUout !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo got %h want 0", FPUout); end
    tests++; if (FPUoutHi !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi got %h want 0", FPUoutHi); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
  endtask

  logic [31:0] dA  [5] = '{32'd2, 32'd2, 32'd2, 32'd1000, 32'h80000000};
  logic [31:0] dB  [5] = '{32'd8, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'd2000, 32'h80000000};
  logic        dM  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] dLo [5] = '{32'd16, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'd2000000, 32'h0};
  logic [31:0] dHi [5] = '{32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h40000000};
  logic        dO  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic test_directed;
    int lat; logic [31:0] lo, hi; logic o;
    for (int k = 0; k < 5; k++) begin
      startOp(dA[k], dB[k], dM[k]);
      tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL dir%0d_busy got %b want 1", k, busy); end
      waitDone(lat, lo, hi, o);
      tests++; if (lat != LAT) begin fails++; $display("[TB] FAIL dir%0d_latency got %0d want %0d", k, lat, LAT); end
      tests++; if (lo !== dLo[k]) begin fails++; $display("[TB] FAIL dir%0d_lo got %h want %h", k, lo, dLo[k]); end
      tests++; if (hi !== dHi[k]) begin fails++; $display("[TB] FAIL dir%0d_hi got %h want %h", k, hi, dHi[k]); end
      tests++; if (o !== dO[k]) begin fails++; $display("[TB] FAIL dir%0d_ovf got %b want %b", k, o, dO[k]); end
      @(posedge clk); #1;
      tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL dir%0d_done_pulse got %b want 0", k, done); end
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] lo, hi, prevLo, prevHi; logic o;
    startOp(32'd3, 32'd5, 1'b0);
    waitDone(lat, prevLo, prevHi, o);
    tests++; if (prevLo !== 32'd15) begin fails++; $display("[TB] FAIL b2b_first_lo got %h want %h", prevLo, 32'd15); end
    startOp(32'd35, 32'hFFFFFFF8, 1'b0);
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL b2b_done_drop got %b want 0", done); end
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accepted got %b want 1", busy); end
    tests++; if (FPUout !== 32'd15) begin fails++; $display("[TB] FAIL b2b_hold_lo got %h want %h", FPUout, 32'd15); end
    waitDone(lat, lo, hi, o);
    tests++; if (lat != LAT) begin fails++; $display("[TB] FAIL b2b_latency got %0d want %0d", lat, LAT); end
    tests++; if (lo !== 32'hFFFFFEE8) begin fails++; $display("[TB] FAIL b2b_lo got %h want FFFFFEE8", lo); end
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL b2b_hi got %h want FFFFFFFF", hi); end
    tests++; if (o !== 1'b0) begin fails++; $display("[TB] FAIL b2b_ovf got %b want 0", o); end
  endtask

  task automatic test_ignore_start;
    int lat; logic [31:0] lo, hi; logic o; logic [63:0] p;
    p = refProduct(32'd123456, 32'hFFFF0001, 1'b1);
    startOp(32'd123456, 32'hFFFF0001, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    fbusA = 32'd7; fbusB = 32'd9; FPUctrl = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(lat, lo, hi, o);
    lat = lat + 10;
    tests++; if (lat != LAT) begin fails++; $display("[TB] FAIL ign_latency got %0d want %0d", lat, LAT); end
    tests++; if ({hi, lo} !== p) begin fails++; $display("[TB] FAIL ign_product got %h want %h", {hi, lo}, p); end
    tests++; if (o !== refOvf(p, 1'b1)) begin fails++; $display("[TB] FAIL ign_ovf got %b want %b", o, refOvf(p, 1'b1)); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ign_no_queue got %b want 0", busy); end
  endtask

  task automatic test_reset_abort;
    int pulses = 0;
    startOp(32'd77, 32'd99, 1'b0);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    tests++; if ({FPUoutHi, FPUout} !== 64'h0) begin fails++; $display("[TB] FAIL abort_out got %h want 0", {FPUoutHi, FPUout}); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("[TB] FAIL abort_ovf got %b want 0", ovf); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("[TB] FAIL abort_no_done got %0d want 0", pulses); end
  endtask

  task automatic test_random;
    int lat; logic [31:0] lo, hi, a, b; logic o, m; logic [63:0] p;
    for (int k = 0; k < 24; k++) begin
      a = $urandom; b = $urandom; m = 1'($urandom);
      if (k == 0) a = 32'h0;
      if (k == 1) b = 32'hFFFFFFFF;
      if (k == 2) begin a = 32'h7FFFFFFF; b = 32'h80000000; end
      p = refProduct(a, b, m);
      startOp(a, b, m);
      waitDone(lat, lo, hi, o);
      tests++; if (lat != LAT) begin fails++; $display("[TB] FAIL rnd%0d_latency got %0d want %0d", k, lat, LAT); end
      tests++; if ({hi, lo} !== p) begin fails++; $display("[TB] FAIL rnd%0d_product a=%h b=%h m=%b got %h want %h", k, a, b, m, {hi, lo}, p); end
      tests++; if (o !== refOvf(p, m)) begin fails++; $display("[TB] FAIL rnd%0d_ovf got %b want %b", k, o, refOvf(p, m)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
